// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares one AXI4 read channel between icache and dcache, one burst at a time.
// Define CACHE_RD_ARB_RR_EN for round-robin arbitration; otherwise dcache wins every tie.
module cache_rd_arbiter (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_rd_req,
    input  logic         i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic [255:0] i_ret_data,
    input  logic         d_rd_req,
    input  logic         d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic [255:0] d_ret_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);
    localparam logic [3:0] IDLE = 4'b0001, AR = 4'b0010, R = 4'b0100, RET = 4'b1000;
    logic [3:0]   state, next_state;
    logic         owner, rtype, done, i_grant, d_grant, accept;
    logic [31:0]  addr;
    logic [2:0]   cnt;
    logic [255:0] line;
`ifdef CACHE_RD_ARB_RR_EN
    logic last_grant;
    always_ff @(posedge clk)
        last_grant <= !resetn ? 1'b1 : accept ? d_grant : last_grant;
    assign d_grant = d_rd_req & (~i_rd_req | ~last_grant);
`else
    assign d_grant = d_rd_req;
`endif
    assign i_grant = i_rd_req & ~d_grant;
    assign accept  = (state == IDLE) & (i_grant | d_grant);
    always_ff @(posedge clk)
        state <= !resetn ? IDLE : next_state;
    always_comb begin
        next_state = (state == IDLE) ? (accept ? AR : IDLE) :
                     (state == AR)   ? (arready ? R : AR) :
                     (state == R)    ? (rvalid && rlast ? RET : R) : IDLE;
    end
    always_comb begin
        i_rd_rdy    = (state == IDLE) & i_grant;
        d_rd_rdy    = (state == IDLE) & d_grant;
        arvalid     = state == AR;
        rready      = state == R;
        i_ret_valid = (state == RET) & ~owner;
        d_ret_valid = (state == RET) & owner;
    end
    // done blocks writes past the eighth beat; only rlast ends the burst
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner <= 1'b0;
            rtype <= 1'b0;
            addr  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            line  <= '0;
        end else if (accept) begin
            owner <= d_grant;
            rtype <= d_grant ? d_rd_type : i_rd_type;
            addr  <= d_grant ? d_rd_addr : i_rd_addr;
            cnt   <= '0;
            done  <= 1'b0;
            line  <= '0;
        end else if (state == R && rvalid && !done) begin
            line[{cnt, 5'b0} +: 32] <= rdata;
            cnt  <= cnt + {2'b0, cnt != 3'd7};
            done <= cnt == 3'd7;
        end
    end
    assign arid       = {3'b0, owner};
    assign araddr     = addr;
    assign arlen      = rtype ? 8'd7 : 8'd0;
    assign arsize     = 3'b010;
    assign arburst    = 2'b01;
    assign i_ret_data = line;
    assign d_ret_data = line;
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb_cache_rd_arbiter: directed-vector bench for cache_rd_arbiter with a small AXI read slave model.
module tb_cache_rd_arbiter;
    logic         clk = 0, resetn = 0;
    logic         i_rd_req = 0, i_rd_type = 0, d_rd_req = 0, d_rd_type = 0;
    logic [31:0]  i_rd_addr = 0, d_rd_addr = 0;
    logic         i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid;
    logic [255:0] i_ret_data, d_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, rready;
    logic         arready = 0, rlast = 0, rvalid = 0;
    logic [31:0]  rdata = 0;
    int           errors = 0, checks = 0;

    cache_rd_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise a request at a negedge, wait (bounded) for rd_rdy, return at the negedge of the AR cycle.
    task automatic request(input logic is_d, input logic typ, input logic [31:0] addr);
        bit ok = 0;
        @(negedge clk);
        if (is_d) begin d_rd_req = 1; d_rd_type = typ; d_rd_addr = addr; end
        else begin i_rd_req = 1; i_rd_type = typ; i_rd_addr = addr; end
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            ok = is_d ? d_rd_rdy : i_rd_rdy;
            if (!ok) @(negedge clk);
        end
        chk("rd_rdy", ok, 1);
        @(negedge clk);
        if (is_d) d_rd_req = 0; else i_rd_req = 0;
    endtask

    // Slave side: AR handshake after ar_wait stall cycles, n beats of base*(k+1) with gap idle cycles before each.
    task automatic serve(input logic own, input logic [31:0] addr, input logic typ,
                         input int ar_wait, input int gap, input int n, input logic [31:0] base);
        logic [255:0] exp_line;
        exp_line = '0;
        chk("arvalid", arvalid, 1);
        chk("arid", arid, {3'b0, own});
        chk("araddr", araddr, addr);
        chk("arlen", arlen, typ ? 8'd7 : 8'd0);
        chk("arsize_arburst", {arsize, arburst}, 5'b010_01);
        chk("ar_no_rready", rready, 0);
        for (int k = 0; k < ar_wait; k++) begin
            @(negedge clk);
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, addr);
            chk("ar_hold_len", arlen, typ ? 8'd7 : 8'd0);
            chk("ar_hold_no_rready", rready, 0);
        end
        arready = 1;
        @(negedge clk);
        arready = 0;
        chk("arvalid_drop", arvalid, 0);
        chk("rready", rready, 1);
        for (int k = 0; k < n; k++) begin
            repeat (gap) @(negedge clk);
            chk("no_early_ret", {i_ret_valid, d_ret_valid}, 2'b00);
            rvalid = 1;
            rdata  = base * (k + 1);
            rlast  = k == n - 1;
            if (k < 8) exp_line[k*32 +: 32] = base * (k + 1);
            @(negedge clk);
            rvalid = 0;
            rlast  = 0;
        end
        chk("own_ret_valid", own ? d_ret_valid : i_ret_valid, 1);
        chk("other_ret_valid", own ? i_ret_valid : d_ret_valid, 0);
        chk("ret_data", own ? d_ret_data : i_ret_data, exp_line);
        @(negedge clk);
        chk("ret_pulse_end", {i_ret_valid, d_ret_valid}, 2'b00);
    endtask

    initial begin
        bit exp_d;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {i_rd_rdy, d_rd_rdy}, 2'b00);
        chk("rst_ret_valid", {i_ret_valid, d_ret_valid}, 2'b00);
        chk("rst_ar_r", {arvalid, rready}, 2'b00);
        chk("rst_ret_data", i_ret_data | d_ret_data, 0);
        chk("rst_ar_fields", {arid, araddr, arlen}, 0);
        resetn = 1;

        request(1, 0, 32'hBFAF_F004);
        serve(1, 32'hBFAF_F004, 0, 0, 0, 1, 32'hDEAD_BEEF);

        request(0, 1, 32'h1FC0_0020);
        serve(0, 32'h1FC0_0020, 1, 0, 0, 8, 32'h0000_0011);

        for (int r = 0; r < 3; r++) begin
`ifdef CACHE_RD_ARB_RR_EN
            exp_d = r != 1;
`else
            exp_d = 1;
`endif
            @(negedge clk);
            i_rd_req = 1; i_rd_type = 0; i_rd_addr = 32'h0000_1000;
            d_rd_req = 1; d_rd_type = 0; d_rd_addr = 32'h0000_2000;
            #1;
            chk("arb_d_rdy", d_rd_rdy, exp_d);
            chk("arb_i_rdy", i_rd_rdy, !exp_d);
            @(negedge clk);
            i_rd_req = 0; d_rd_req = 0;
            serve(exp_d, exp_d ? 32'h0000_2000 : 32'h0000_1000, 0, 0, 0, 1, 32'h100 + r);
        end

        request(1, 1, 32'h0000_4000);
        i_rd_req = 1; i_rd_type = 0; i_rd_addr = 32'h0000_5004;
        #1;
        chk("busy_rdy", i_rd_rdy, 0);
        serve(1, 32'h0000_4000, 1, 5, 0, 8, 32'h0102_0304);
        #1;
        chk("turnaround_rdy", i_rd_rdy, 1);
        @(negedge clk);
        i_rd_req = 0;
        serve(0, 32'h0000_5004, 0, 0, 0, 1, 32'hCAFE_F00D);

        request(0, 1, 32'h0000_6000);
        serve(0, 32'h0000_6000, 1, 0, 2, 8, 32'h1111_0001);

        request(1, 1, 32'h0000_7000);
        serve(1, 32'h0000_7000, 1, 0, 0, 9, 32'h0000_0A05);

        request(0, 1, 32'h1FC0_0100);
        arready = 1;
        @(negedge clk);
        arready = 0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1; rdata = k + 1; rlast = 0;
            @(negedge clk);
            rvalid = 0;
        end
        resetn = 0;
        @(negedge clk);
        chk("abort_ar_r", {arvalid, rready}, 2'b00);
        chk("abort_ret_valid", {i_ret_valid, d_ret_valid}, 2'b00);
        resetn = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle", {arvalid, rready, i_ret_valid, d_ret_valid}, 4'b0000);
        end
        request(0, 1, 32'h1FC0_0200);
        serve(0, 32'h1FC0_0200, 1, 0, 0, 8, 32'h0101_0101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_rd_arbiter.md
# cache_rd_arbiter

Shares a single AXI4 read channel between the instruction cache and the data cache. It accepts each cache's rd_req/rd_type/rd_addr request, issues one AXI read burst at a time, and packs the returned 32-bit beats into a 256-bit line. The packed line goes back through the requester's ret_valid/ret_data. It sits between both caches and the AXI crossbar, and only one transaction is outstanding at any time.

## Interface
- Parameters: none.
- clk  in  1  clock
- resetn  in  1  reset resetn, synchronous, active-low; clock clk
- i_rd_req / d_rd_req  in  1  read request from icache / dcache
- i_rd_type / d_rd_type  in  1  1 = 8-word cache line, 0 = single uncached word
- i_rd_addr / d_rd_addr  in  32  request address (line-aligned when type=1)
- i_rd_rdy / d_rd_rdy  out  1  request accepted this cycle
- i_ret_valid / d_ret_valid  out  1  one-cycle pulse, data returned
- i_ret_data / d_ret_data  out  256  returned line; word 0 in [31:0]
- arid  out  4  0 = icache, 1 = dcache
- araddr  out  32  burst address
- arlen  out  8  7 for line, 0 for word
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rdata  in  32  read beat data
- rlast  in  1  last beat of the burst
- rvalid  in  1  beat valid
- rready  out  1  beat accepted

## Operation
- FSM states: IDLE, AR, R, RET (one-hot).
- IDLE:
  - Arbitrates between the pending requests.
  - Asserts the winner's rd_rdy combinationally in the same cycle as its rd_req. Never asserts both rd_rdy.
  - On accept, latches owner, type and addr; next state AR.
- AR:
  - arvalid=1 with the latched fields; araddr = latched addr.
  - Fields stay stable until arready. On arvalid&&arready, next state R.
- R:
  - rready=1.
  - Each beat with rvalid writes rdata into line word[cnt]; a 3-bit counter then increments.
  - Word (type=0) request: the line buffer is cleared on accept, so bits [255:32] return as 0.
  - On rvalid&&rlast, next state RET.
  - Beats beyond 8 are ignored and the counter saturates at 7. rlast alone ends the burst.
- RET:
  - Owner's ret_valid=1 for exactly one cycle; next state IDLE.
  - The non-owner's ret_valid stays 0.
- ret_data:
  - Both ret_data buses drive the line buffer continuously.
  - They are meaningful only while the matching ret_valid is high.
- rid and rresp are not ported. Error responses are not reported.

## Timing
- Reset values: all rd_rdy=0, all ret_valid=0, arvalid=0, rready=0, ret_data=0, arid=0, araddr=0, arlen=0; state IDLE; counter 0.
- Request accept at cycle 0 → arvalid first high at cycle 1.
- Last beat accepted at cycle N → ret_valid high at cycle N+1.
- Minimum turnaround is 1 cycle: after RET, the next rd_rdy can be asserted in the following IDLE cycle.
- Requesters hold rd_req, rd_type and rd_addr until rd_rdy. A request dropped before rd_rdy is never issued.
- Simultaneous requests are resolved per the Configuration section.
- A request arriving while the FSM is not in IDLE waits; rd_rdy stays 0.
- Reset mid-transaction:
  - Returns to IDLE on the next edge and drops arvalid and rready.
  - No ret_valid is issued for the aborted request.
  - The AXI slave is reset by the same resetn.

## Configuration
- CACHE_RD_ARB_RR_EN defined:
  - Round-robin arbitration. A 1-bit last-grant register (reset value 1 = dcache) gives priority to the requester not granted last time.
  - The register updates only on accept.
- CACHE_RD_ARB_RR_EN undefined: fixed priority, dcache wins every tie; no last-grant register.

## Test plan
- Icache line request: i_rd_type=1, i_rd_addr=0x1FC0_0020.
  - Required: arid=0, araddr=0x1FC0_0020, arlen=7.
  - Beats 0x11..0x88 → i_ret_valid pulse one cycle after rlast with i_ret_data={0x88,…,0x11}; d_ret_valid stays 0.
- Dcache uncached word: d_rd_type=0, addr 0xBFAF_F004, rdata=0xDEADBEEF.
  - Required: arlen=0, arid=1.
  - d_ret_data[31:0]=0xDEADBEEF, [255:32]=0.
- Simultaneous requests, three back-to-back rounds.
  - Fixed priority: dcache is granted in all three rounds.
  - RR_EN: grants alternate d, i, d.
- arready held low 5 cycles.
  - Required: arvalid, araddr and arlen stay stable; no rready until after the handshake.
- rvalid gaps (beats every 3rd cycle).
  - Required: correct word packing; ret_valid exactly one cycle after the rlast beat.
- resetn low for 1 cycle after beat 3 of a line burst.
  - Required: state returns to IDLE; no ret_valid for the aborted request; a new request is then served normally.
